star_collect_ctrl: RTL and testbench
====================================

# star_collect_ctrl

Scheduler that sits between the star objects and the score/sound logic. It collects the single-cycle `touch_starN` pulses from up to `N_STARS` star instances and queues them in a pending bitmap. It then presents them one at a time to the scoreboard over a req/ack handshake, using fixed lowest-index priority. It also keeps the collected count, flags level completion, and re-arms all stars on a level restart.

## Interface
- `N_STARS`, 4: number of star instances serviced, 1..8.
- `CNT_W`, 3: width of the collected counter; must satisfy 2^CNT_W > N_STARS.
- `sys_clk`  in  1  system clock; all state changes on its rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `touch`  in  N_STARS  bit i is the `touch_star` pulse of star i, one cycle wide.
- `level_restart`  in  1  synchronous single-cycle request to restart the level.
- `score_ack`  in  1  scoreboard accepts the current event.
- `score_req`  out  1  a scoring event is being offered.
- `score_id`  out  3  index of the star being offered; valid only while `score_req`=1.
- `collected_cnt`  out  CNT_W  number of stars acknowledged since reset or restart.
- `all_collected`  out  1  level-complete level signal.
- `stars_rearm`  out  1  one-cycle pulse telling the star objects to re-enable.

## Operation
- Registers:
  - `collected_mask[N_STARS]`: stars already captured.
  - `pending[N_STARS]`: captured but not yet acknowledged.
  - `state`, `score_id`, `collected_cnt`, `all_collected`, `stars_rearm`.
- Capture: every cycle, `pending |= touch & ~collected_mask` and `collected_mask |= touch`.
  - A repeated touch on an already-captured star is ignored.
  - Several bits may arrive in one cycle.
- FSM has three states:
  - IDLE: if `pending != 0`, load `score_id` with the lowest set index of `pending` and go to REQ. Only the registered `pending` is examined; bits captured in the same cycle are not.
  - REQ: `score_req`=1 and `score_id` held stable.
    - On `score_ack`=1: clear `pending[score_id]`, `collected_cnt += 1`, go to GAP.
    - Otherwise stay in REQ. No timeout; the request is never withdrawn.
  - GAP: one cycle, `score_req`=0, then IDLE. This guarantees one idle cycle between events.
- Completion: `all_collected` is set in the cycle after the ack that brings `collected_cnt` to N_STARS. It stays 1 until reset or restart.
- Counter arithmetic: `collected_cnt` is unsigned. It cannot exceed N_STARS, so it never wraps.
- `level_restart`=1 overrides everything, in any state including REQ:
  - On the next edge: `pending`, `collected_mask`, `collected_cnt` and `all_collected` are cleared, and `state` goes to IDLE.
  - `score_req` drops without an ack.
  - `stars_rearm`=1 for exactly that one following cycle.
  - `touch` bits arriving in the restart cycle are discarded.
  - A `score_ack` in the restart cycle is ignored; the count is not incremented.
- `score_ack` while not in REQ is ignored.

## Timing
- Reset values (RST_N=0, asynchronous):
  - `score_req`=0, `score_id`=0, `collected_cnt`=0, `all_collected`=0, `stars_rearm`=0.
  - `pending`=0, `collected_mask`=0, state IDLE.
- Latency from a touch pulse in cycle k (FSM in IDLE, nothing queued):
  - `pending` bit set in k+1.
  - `score_req`=1 with a valid `score_id` in k+2.
- Ack handshake: `score_ack` sampled high in cycle m, with `score_req`=1 in m, gives:
  - `score_req`=0 and `collected_cnt` updated in m+1 (GAP).
  - Earliest next `score_req` in m+3.
- Sustained throughput with a zero-wait ack: one event per 3 cycles.
- `all_collected` rises in m+1 of the final ack.
- `level_restart` in cycle r gives cleared state and `stars_rearm`=1 in r+1, and `stars_rearm`=0 in r+2.
- Asynchronous reset mid-REQ drops `score_req` immediately. The event is lost; this is by design.

## Structure
- Shared game package holds:
  - `N_STARS_DEF`=4.
  - State encoding localparams: IDLE=2'd0, REQ=2'd1, GAP=2'd2.
  - The `score_id` width, 3.
- One sub-module, `lowest_set_enc`: combinational priority encoder giving the index of the lowest set bit plus an `any` flag, parameterised on width.

## Test plan
- Single star, scoreboard holding `score_ack`=1: pulse `touch`=4'b0100 in cycle 10.
  - `score_req`=1 and `score_id`=2 in cycle 12.
  - `collected_cnt`=1 in cycle 13.
- Simultaneous capture: `touch`=4'b1010 in one cycle, ack held high.
  - Events issued as id 1 then id 3, exactly 3 cycles apart.
  - `collected_cnt` goes 1 then 2.
- Back-pressure: `score_ack`=0 for 20 cycles after `score_req` rises.
  - `score_req` and `score_id` stay stable for all 20 cycles.
  - Ack on cycle 21 gives exactly one count increment.
- Duplicate touch: star 0 pulses twice, 5 cycles apart.
  - Exactly one event and `collected_cnt`=1.
- Completion: touch all 4 stars in sequence with ack high.
  - `all_collected`=1 in the cycle after the 4th ack, then stays 1.
- Restart during REQ: `score_ack`=0 and `level_restart`=1 while in REQ.
  - Next cycle: `score_req`=0, `collected_cnt`=0, `stars_rearm`=1 for one cycle.
  - A following touch on the same star is accepted again.

Source files
------------

// File: rtl/star_collect_ctrl_pkg.sv
// Shared game definitions for the star collection scheduler.
package star_collect_ctrl_pkg;

    localparam int unsigned N_STARS_DEF = 4;
    localparam int unsigned ID_W        = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_REQ  = REQ,
        ST_GAP  = GAP
    } state_e;

endpackage

// File: rtl/star_collect_ctrl_lowest_set_enc.sv
// Priority encoder: index of the lowest set bit and an any-bit-set flag.
module lowest_set_enc
    import star_collect_ctrl_pkg::*;
#(
    parameter int unsigned W = N_STARS_DEF
) (
    input  logic [W-1:0]    vec_i,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/star_collect_ctrl.sv
// Collects star touch pulses and offers them one at a time to the scoreboard.
module star_collect_ctrl
    import star_collect_ctrl_pkg::*;
#(
    parameter int unsigned N_STARS = N_STARS_DEF,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               sys_clk,
    input  logic               RST_N,
    input  logic [N_STARS-1:0] touch,
    input  logic               level_restart,
    input  logic               score_ack,
    output logic               score_req,
    output logic [ID_W-1:0]    score_id,
    output logic [CNT_W-1:0]   collected_cnt,
    output logic               all_collected,
    output logic               stars_rearm
);

    localparam logic [N_STARS-1:0] BIT0   = N_STARS'(1);
    localparam logic [CNT_W-1:0]   LAST_M1 = CNT_W'(N_STARS - 1);

    state_e             state_q;
    logic [N_STARS-1:0] pend_q, pend_d;
    logic [N_STARS-1:0] mask_q, mask_d;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               all_q;
    logic               rearm_q;
    logic               req_q;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_any;

    lowest_set_enc #(.W(N_STARS)) u_enc (
        .vec_i (pend_q),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // Capture new touches; retire the offered star once acknowledged.
    always_comb begin
        mask_d = mask_q | touch;
        pend_d = pend_q | (touch & ~mask_q);
        if (state_q == ST_REQ && score_ack) begin
            pend_d = pend_d & ~(BIT0 << id_q);
        end
    end

    // Offer FSM, counter and completion flag; restart overrides everything.
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            all_q   <= 1'b0;
            rearm_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            rearm_q <= 1'b0;
            if (level_restart) begin
                state_q <= ST_IDLE;
                pend_q  <= '0;
                mask_q  <= '0;
                cnt_q   <= '0;
                all_q   <= 1'b0;
                req_q   <= 1'b0;
                rearm_q <= 1'b1;
            end else begin
                pend_q <= pend_d;
                mask_q <= mask_d;
                case (state_q)
                    ST_IDLE: begin
                        if (enc_any) begin
                            id_q    <= enc_idx;
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (score_ack) begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == LAST_M1) begin
                                all_q <= 1'b1;
                            end
                            req_q   <= 1'b0;
                            state_q <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign score_req     = req_q;
    assign score_id      = id_q;
    assign collected_cnt = cnt_q;
    assign all_collected = all_q;
    assign stars_rearm   = rearm_q;

endmodule

// File: tb/tb_star_collect_ctrl.sv
// Bench for star_collect_ctrl: directed scenarios plus random traffic vs. a behavioural model.
module tb_star_collect_ctrl;

    localparam int N = 4;

    logic         sys_clk = 1'b0;
    logic         RST_N;
    logic [N-1:0] touch;
    logic         level_restart;
    logic         score_ack;
    logic         score_req;
    logic [2:0]   score_id;
    logic [2:0]   collected_cnt;
    logic         all_collected;
    logic         stars_rearm;

    int total = 0;
    int bad   = 0;

    star_collect_ctrl #(.N_STARS(N), .CNT_W(3)) dut (
        .sys_clk       (sys_clk),
        .RST_N         (RST_N),
        .touch         (touch),
        .level_restart (level_restart),
        .score_ack     (score_ack),
        .score_req     (score_req),
        .score_id      (score_id),
        .collected_cnt (collected_cnt),
        .all_collected (all_collected),
        .stars_rearm   (stars_rearm)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- behavioural model ----------------
    // Offer = star index currently presented (-1 when none); a gap of one cycle follows every accepted event.
    bit [N-1:0] m_pend, m_seen;
    int         m_offer, m_cnt;
    bit         m_gap, m_all, m_rearm;
    bit [N-1:0] w_pend;
    int         w_offer, w_cnt;
    bit         w_gap, w_all;

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            m_pend <= '0; m_seen <= '0; m_offer <= -1; m_cnt <= 0;
            m_gap <= 1'b0; m_all <= 1'b0; m_rearm <= 1'b0;
        end else if (level_restart) begin
            m_pend <= '0; m_seen <= '0; m_offer <= -1; m_cnt <= 0;
            m_gap <= 1'b0; m_all <= 1'b0; m_rearm <= 1'b1;
        end else begin
            w_pend = m_pend; w_offer = m_offer; w_gap = m_gap; w_cnt = m_cnt; w_all = m_all;
            if (w_offer >= 0) begin
                if (score_ack) begin
                    w_pend[w_offer] = 1'b0;
                    w_cnt   = w_cnt + 1;
                    if (w_cnt == N) w_all = 1'b1;
                    w_offer = -1;
                    w_gap   = 1'b1;
                end
            end else if (w_gap) begin
                w_gap = 1'b0;
            end else if (w_pend != '0) begin
                w_offer = lowest(w_pend);
            end
            for (int i = 0; i < N; i++) if (touch[i] && !m_seen[i]) w_pend[i] = 1'b1;
            m_pend  <= w_pend;
            m_seen  <= m_seen | touch;
            m_offer <= w_offer;
            m_gap   <= w_gap;
            m_cnt   <= w_cnt;
            m_all   <= w_all;
            m_rearm <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_restart();
        touch = '0; score_ack = 1'b0; level_restart = 1'b1;
        next_cycle();
        level_restart = 1'b0;
        next_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST_N = 1'b0; touch = '0; level_restart = 1'b0; score_ack = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if ({score_req, score_id, collected_cnt, all_collected, stars_rearm} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs got req=%b id=%0d cnt=%0d all=%b rearm=%b want all zero",
                     score_req, score_id, collected_cnt, all_collected, stars_rearm);
        end
        RST_N = 1'b1;
        next_cycle();
    endtask

    task automatic test_single();
        logic [7:0] exp_req;
        logic [2:0] exp_cnt [6];
        exp_req = 8'b0000_0100;   // bit c = expected score_req in cycle T+c
        exp_cnt = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
        do_restart();
        score_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            touch = (c == 0) ? 4'b0100 : 4'b0000;
            @(negedge sys_clk);
            total++;
            if (score_req !== exp_req[c] || (exp_req[c] && score_id !== 3'd2)) begin
                bad++;
                $display("FAIL single_req c=%0d got req=%b id=%0d want req=%b id=2", c, score_req, score_id, exp_req[c]);
            end
            total++;
            if (collected_cnt !== exp_cnt[c]) begin
                bad++;
                $display("FAIL single_cnt c=%0d got %0d want %0d", c, collected_cnt, exp_cnt[c]);
            end
            next_cycle();
        end
        score_ack = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [8:0] exp_req;
        logic [2:0] exp_id  [9];
        logic [2:0] exp_cnt [9];
        exp_req = 9'b0_0010_0100;
        exp_id  = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0};
        exp_cnt = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
        do_restart();
        score_ack = 1'b1;
        for (int c = 0; c < 9; c++) begin
            touch = (c == 0) ? 4'b1010 : 4'b0000;
            @(negedge sys_clk);
            total++;
            if (score_req !== exp_req[c] || (exp_req[c] && score_id !== exp_id[c])) begin
                bad++;
                $display("FAIL simul_req c=%0d got req=%b id=%0d want req=%b id=%0d", c, score_req, score_id, exp_req[c], exp_id[c]);
            end
            total++;
            if (collected_cnt !== exp_cnt[c]) begin
                bad++;
                $display("FAIL simul_cnt c=%0d got %0d want %0d", c, collected_cnt, exp_cnt[c]);
            end
            next_cycle();
        end
        score_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        do_restart();
        score_ack = 1'b0;
        touch = 4'b0001;
        next_cycle();
        touch = 4'b0000;
        next_cycle();
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            total++;
            if (score_req !== 1'b1 || score_id !== 3'd0 || collected_cnt !== 3'd0) begin
                bad++;
                $display("FAIL backpressure_hold c=%0d got req=%b id=%0d cnt=%0d want req=1 id=0 cnt=0",
                         c, score_req, score_id, collected_cnt);
            end
            next_cycle();
        end
        score_ack = 1'b1;
        next_cycle();
        score_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge sys_clk);
            total++;
            if (score_req !== 1'b0 || collected_cnt !== 3'd1) begin
                bad++;
                $display("FAIL backpressure_ack c=%0d got req=%b cnt=%0d want req=0 cnt=1", c, score_req, collected_cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_duplicate();
        int req_cycles;
        do_restart();
        score_ack = 1'b1;
        req_cycles = 0;
        for (int c = 0; c < 14; c++) begin
            touch = (c == 0 || c == 5) ? 4'b0001 : 4'b0000;
            @(negedge sys_clk);
            if (score_req) req_cycles++;
            next_cycle();
        end
        total++;
        if (req_cycles != 1 || collected_cnt !== 3'd1) begin
            bad++;
            $display("FAIL duplicate got events=%0d cnt=%0d want events=1 cnt=1", req_cycles, collected_cnt);
        end
        score_ack = 1'b0;
    endtask

    task automatic test_completion();
        bit seen;
        do_restart();
        score_ack = 1'b1;
        for (int s = 0; s < N; s++) begin
            touch = 4'(1 << s);
            next_cycle();
            touch = '0;
            seen = 1'b0;
            for (int w = 0; w < 8 && !seen; w++) begin
                @(negedge sys_clk);
                if (score_req) seen = 1'b1;
                else next_cycle();
            end
            total++;
            if (!seen || score_id !== 3'(s) || all_collected !== 1'b0) begin
                bad++;
                $display("FAIL completion_event s=%0d got seen=%b id=%0d all=%b want seen=1 id=%0d all=0",
                         s, seen, score_id, all_collected, s);
            end
            next_cycle();
        end
        score_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge sys_clk);
            total++;
            if (all_collected !== 1'b1 || collected_cnt !== 3'd4) begin
                bad++;
                $display("FAIL completion_flag c=%0d got all=%b cnt=%0d want all=1 cnt=4", c, all_collected, collected_cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_restart();
        bit seen;
        do_restart();
        score_ack = 1'b0;
        touch = 4'b0100;
        next_cycle();
        touch = '0;
        next_cycle();
        @(negedge sys_clk);
        total++;
        if (score_req !== 1'b1 || score_id !== 3'd2) begin
            bad++;
            $display("FAIL restart_pre got req=%b id=%0d want req=1 id=2", score_req, score_id);
        end
        next_cycle();
        level_restart = 1'b1;
        next_cycle();
        level_restart = 1'b0;
        @(negedge sys_clk);
        total++;
        if (score_req !== 1'b0 || collected_cnt !== 3'd0 || stars_rearm !== 1'b1) begin
            bad++;
            $display("FAIL restart_r1 got req=%b cnt=%0d rearm=%b want req=0 cnt=0 rearm=1", score_req, collected_cnt, stars_rearm);
        end
        next_cycle();
        @(negedge sys_clk);
        total++;
        if (stars_rearm !== 1'b0 || score_req !== 1'b0) begin
            bad++;
            $display("FAIL restart_r2 got rearm=%b req=%b want rearm=0 req=0", stars_rearm, score_req);
        end
        touch = 4'b0100;
        next_cycle();
        touch = '0;
        seen = 1'b0;
        for (int w = 0; w < 6 && !seen; w++) begin
            @(negedge sys_clk);
            if (score_req && score_id === 3'd2) seen = 1'b1;
            else next_cycle();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL restart_retouch got no event want id=2");
        end
        // Ack coinciding with a restart must not count.
        next_cycle();
        score_ack = 1'b1; level_restart = 1'b1;
        next_cycle();
        score_ack = 1'b0; level_restart = 1'b0;
        @(negedge sys_clk);
        total++;
        if (collected_cnt !== 3'd0 || score_req !== 1'b0) begin
            bad++;
            $display("FAIL restart_ack got cnt=%0d req=%b want cnt=0 req=0", collected_cnt, score_req);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_restart();
        touch = 4'b1000;
        next_cycle();
        touch = '0;
        next_cycle();
        #1;
        RST_N = 1'b0;
        #1;
        total++;
        if (score_req !== 1'b0 || score_id !== 3'd0) begin
            bad++;
            $display("FAIL async_reset got req=%b id=%0d want req=0 id=0", score_req, score_id);
        end
        @(negedge sys_clk);
        RST_N = 1'b1;
        next_cycle();
    endtask

    task automatic test_random();
        do_restart();
        for (int c = 0; c < 400; c++) begin
            touch         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            score_ack     = ($urandom_range(0, 1) == 1);
            level_restart = ($urandom_range(0, 49) == 0);
            @(negedge sys_clk);
            total++;
            if (score_req !== (m_offer >= 0) || (m_offer >= 0 && score_id !== 3'(m_offer))) begin
                bad++;
                $display("FAIL random_req c=%0d got req=%b id=%0d want offer=%0d", c, score_req, score_id, m_offer);
            end
            total++;
            if (collected_cnt !== 3'(m_cnt) || all_collected !== m_all || stars_rearm !== m_rearm) begin
                bad++;
                $display("FAIL random_state c=%0d got cnt=%0d all=%b rearm=%b want cnt=%0d all=%b rearm=%b",
                         c, collected_cnt, all_collected, stars_rearm, m_cnt, m_all, m_rearm);
            end
            next_cycle();
        end
        touch = '0; score_ack = 1'b0; level_restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_duplicate();
        test_completion();
        test_restart();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
